// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-bus client.
// Provides bus widths, command op codes, client FSM state encoding,
// the queued command record and a small op-classification helper.
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_DEC   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // INC/DEC are read-modify-write: a read access followed by a write.
    function automatic logic is_rmw(input logic [1:0] op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// mem_cmd_fifo: DEPTH-entry command queue in front of the bus FSM.
// Ports:
//   clk, rst         clock, synchronous active-high reset (empties the queue)
//   push, wr_cmd     enqueue wr_cmd (ignored when full)
//   pop, rd_cmd      dequeue; rd_cmd always shows the head entry
//   full, empty      occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module mem_cmd_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t wr_cmd,
    input  logic pop,
    output cmd_t rd_cmd,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    cmd_t             slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_cmd  = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= wr_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leave the count unchanged.
            if (do_push && !do_pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/mem_client.sv
// mem_client: initiator-side adapter between a pipeline stage and the
// shared 8-bit memory bus arbiter. Queues READ/WRITE/INC/DEC commands,
// runs the request/ready handshake (two accesses for INC/DEC) and returns
// one response pulse per command.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_op/cmd_addr/cmd_data payload
//   rsp_valid/rsp_data           one-cycle completion pulse and result byte
//   request/addr/we/data_out     bus request and access attributes
//   ready/data_in                arbiter completion and read data
//
// state   | meaning
// ST_IDLE | nothing in flight; waiting for a command and for ready low
// ST_REQ  | request high, addr/we/data_out held until ready
// ST_REL  | request dropped, waiting for ready to fall before next access
module mem_client
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              request,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_in
);

    state_t            state;
    cmd_t              head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [1:0]        cur_op;
    logic              rmw_wr;
    logic              rmw_pending;
    logic [DATA_W-1:0] rdata;

    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    // Read half of an INC/DEC is done but its write has not been issued.
    assign rmw_pending = is_rmw(cur_op) && !rmw_wr;

    // A stale ready (still high from the previous grant) blocks any new issue.
    assign pop = !ready && !empty &&
                 ((state == ST_IDLE) || ((state == ST_REL) && !rmw_pending));

    mem_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_cmd ('{op: cmd_op, addr: cmd_addr, data: cmd_data}),
        .pop    (pop),
        .rd_cmd (head),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            request   <= 1'b0;
            addr      <= '0;
            we        <= 1'b0;
            data_out  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            cur_op    <= OP_READ;
            rmw_wr    <= 1'b0;
            rdata     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_REQ: begin
                    if (ready) begin
                        rdata   <= data_in;
                        request <= 1'b0;
                        state   <= ST_REL;
                        if (!rmw_pending) begin
                            rsp_valid <= 1'b1;
                            // WRITE and the RMW write both report the byte driven on the bus.
                            rsp_data  <= (cur_op == OP_READ) ? data_in : data_out;
                        end
                    end
                end
                ST_REL: begin
                    if (!ready) begin
                        if (rmw_pending) begin
                            rmw_wr   <= 1'b1;
                            we       <= 1'b1;
                            data_out <= (cur_op == OP_INC) ? rdata + 8'd1 : rdata - 8'd1;
                            request  <= 1'b1;
                            state    <= ST_REQ;
                        end else if (empty) begin
                            we    <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Loading the next command overrides the IDLE/REL hold paths above.
            if (pop) begin
                cur_op   <= head.op;
                addr     <= head.addr;
                we       <= (head.op == OP_WRITE);
                data_out <= head.data;
                rmw_wr   <= 1'b0;
                request  <= 1'b1;
                state    <= ST_REQ;
            end
        end
    end

endmodule

// File: doc/mem_client.md
# mem_client

Initiator-side adapter for the shared 8-bit memory bus arbiter. A pipeline stage (fetch or exec) hands it byte commands (READ, WRITE, INC, DEC). It runs the arbiter's request/ready handshake, including the read-modify-write sequence for INC/DEC cell ops, and returns one response per command. One instance sits between each client stage and its slice of the arbiter's packed request/addr/we/data vectors.

## Interface
Parameters:
- DEPTH, 2, command queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue not full; command accepted when cmd_valid & cmd_ready at posedge
- cmd_op  in  2  00 READ, 01 WRITE, 10 INC, 11 DEC
- cmd_addr  in  8  target address
- cmd_data  in  8  write data (WRITE only)
- rsp_valid  out  1  one-cycle pulse per completed command
- rsp_data  out  8  READ: value read; WRITE: value written; INC/DEC: new value
- request  out  1  bus request to arbiter
- addr  out  8  bus address
- we  out  1  bus write enable
- data_out  out  8  bus write data
- ready  in  1  arbiter grant/completion for this client
- data_in  in  8  memory read data, valid while ready high

## Operation
- Commands enter a DEPTH-entry FIFO. They execute strictly in order, one bus access at a time.
- FSM states:
  - IDLE: queue empty or ready still high.
  - REQ: request high, addr/we/data_out held stable.
  - REL: request low, waiting for ready low.
- IDLE→REQ: queue non-empty and ready==0. Pop the head into the op register and drive addr=cmd_addr. we=1 only for WRITE.
- REQ, ready==1:
  - Capture data_in into rdata and drop request.
  - If this is the final access, pulse rsp_valid.
  - Go to REL.
- REL, ready==0:
  - RMW write pending: go to REQ with we=1 and data_out=rdata±1.
  - Else queue non-empty: pop and go to REQ.
  - Else: go to IDLE.
- READ: one access, rsp_data=data_in.
- WRITE: one access, rsp_data=cmd_data.
- INC/DEC: read access, then write access of the same addr. rsp_data=new value, pulsed on the write's ready.
- Arithmetic is 8-bit modulo: INC 0xFF→0x00, DEC 0x00→0xFF.
- Stale ready: ready high while in IDLE or REL is never treated as completion. A new request is only issued after ready has been observed low.
- Full queue: cmd_ready=0 and the offer is ignored. A pop and a push in the same cycle are both honoured (count unchanged).
- request never deasserts before ready is seen high. addr/we/data_out never change while request is high.
- Reset mid-operation: FSM→IDLE, request low, queue emptied, in-flight command dropped with no rsp_valid. The arbiter shares rst.

## Timing
- Reset values:
  - request=0, we=0, addr=0x00, data_out=0x00
  - rsp_valid=0, rsp_data=0x00
  - cmd_ready=1, queue empty, FSM IDLE
- With the team arbiter, for request first high in cycle n:
  - ready high in n+2; client captures in n+2.
  - request low from n+3; rsp_valid (if final) in n+3.
  - ready low from n+4; next request visible n+5.
- Command accepted at edge e into an empty idle queue: request visible cycle e+1.
- READ/WRITE: rsp_valid 4 cycles after accept.
- INC/DEC: rsp_valid 9 cycles after accept.
- Back-to-back commands: one access per 5 cycles.

## Structure
- Shared package mem_pkg:
  - op code localparams (OP_READ, OP_WRITE, OP_INC, OP_DEC)
  - FSM state encoding (ST_IDLE, ST_REQ, ST_REL)
  - bus widths ADDR_W=8, DATA_W=8
- Sub-module mem_cmd_fifo holds the {op, addr, data} queue: DEPTH param, push/pop, full/empty, wrap-around pointers.
- FSM, RMW datapath and response register stay in mem_client.

## Test plan
- Reset, then READ addr 0x10 with mem[0x10]=0x5A:
  - request high 1 cycle after accept.
  - rsp_valid one cycle with rsp_data=0x5A.
  - request low before next access.
- WRITE 0x20←0xC3: bus shows addr=0x20, we=1, data_out=0xC3 stable until ready. mem[0x20]=0xC3 afterwards; rsp_data=0xC3.
- INC 0x30 with mem=0xFF, then DEC 0x31 with mem=0x00:
  - Each runs a read then a write of the same addr.
  - Writes 0x00 and 0xFF respectively; exactly one rsp_valid each.
- Push 3 commands back-to-back with DEPTH=2:
  - cmd_ready drops after 2 accepted while the first is executing.
  - All execute in order, 5 cycles apart.
- Hold ready high in IDLE for 3 cycles before issuing READ: no request until ready low, and no spurious rsp_valid.
- Assert rst in the REQ cycle of an INC: request=0 next cycle, queue empty, no rsp_valid, memory unchanged.
